seg7_decode_monitor: RTL and testbench
======================================

# seg7_decode_monitor

Reads the active-low seven-segment pattern driven toward the display by the 3-bit counter/display path and decodes it back into a 3-bit digit. It filters short glitches, flags patterns that are not legal digits, and checks that accepted digits advance by +1 mod 8. It sits on the display bus as an on-chip self-check for the counter and is the receiving end of the digit→segment encoding.

## Interface
- STABLE_CYCLES, default 2: consecutive identical samples required to accept a pattern; legal range ≥1.
- ERR_CNT_W, default 8: width of the saturating error counter.

- CLK  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- iSeg  in  7  segment pattern, active-low: bit6=g … bit0=a.
- oData  out  3  last accepted legal digit.
- oValid  out  1  one-cycle pulse when a legal digit is accepted.
- oIllegal  out  1  one-cycle pulse when a stable pattern is not a legal digit and not blank.
- oBlank  out  1  level; high while the last accepted pattern is blank (7'h7F).
- oLocked  out  1  level; high while the sequence checker is LOCKED.
- oSeqErr  out  1  one-cycle pulse when an accepted legal digit is not the expected next value.
- oErrCount  out  ERR_CNT_W  saturating count of oSeqErr plus oIllegal events.

## Operation
- Legal codes:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30.
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78.
  - Blank = 7'h7F. Every other value is illegal.
- Stability filter:
  - Registers: last sample s_prev (reset 7'h7F) and run counter run (reset 0, saturates at STABLE_CYCLES).
  - Each edge: changed = (iSeg != s_prev). run_next = changed ? 1 : min(run+1, STABLE_CYCLES). s_prev <= iSeg.
  - accept = (run_next == STABLE_CYCLES) && (changed || run != STABLE_CYCLES).
  - Result: exactly one accept per stable run. Runs shorter than STABLE_CYCLES are ignored entirely, with no outputs.
- Classification on accept:
  - Legal digit: oData <= value, oValid pulse, oBlank <= 0.
  - Blank: oBlank <= 1. oData holds; no pulse.
  - Illegal: oIllegal pulse. oData and oBlank hold.
- Sequence checker, states UNLOCKED and LOCKED, with a 3-bit expect register:
  - UNLOCKED + legal accept → LOCKED, expect <= value+1 (mod 8, natural 3-bit wrap). No error.
  - LOCKED + legal accept, value == expect → expect <= value+1, stay LOCKED.
  - LOCKED + legal accept, value != expect → oSeqErr pulse, expect <= value+1 (resync), stay LOCKED.
  - Illegal accept in any state → UNLOCKED. Counts an error via oIllegal.
  - Blank accept in any state → UNLOCKED. No error.
- Wrap-around: 7 → 0 is a correct step.
- A counter reset mid-count shows up as digit 0 while LOCKED. It is reported as one oSeqErr unless expect == 0.
- oErrCount increments by 1 on each cycle in which oSeqErr or oIllegal pulses. The two never pulse together. It holds at all-ones.

## Timing
- All outputs are registered. Reset values: oData=0, oValid=0, oIllegal=0, oBlank=0, oLocked=0, oSeqErr=0, oErrCount=0. Internal state: s_prev=7'h7F, run=0, expect=0, state UNLOCKED.
- Latency: a new pattern first sampled at edge k and held produces its accept-cycle outputs after edge k+STABLE_CYCLES-1.
  - With STABLE_CYCLES=1, outputs update after the same edge that samples the change.
- oValid, oIllegal and oSeqErr are high for exactly one cycle per accept. oSeqErr coincides with its oValid.
- oLocked and oBlank update in the same cycle as the accept that changes them.
- Reset has priority over everything and clears all state in one edge.
  - After reset, an iSeg of 7'h7F held for STABLE_CYCLES edges is accepted as blank (oBlank=1).
  - A partial run in progress at reset is discarded and does not carry over.
- Back-to-back distinct stable patterns, each held exactly STABLE_CYCLES, give back-to-back accepts with no dead cycle.

## Test plan
- **Clean count:** STABLE_CYCLES=2. Drive codes 0..7 then 0, each held 3 cycles → 9 oValid pulses, oData 0,1,…,7,0. oLocked=1 from the first accept. oSeqErr never pulses; oErrCount=0.
- **Glitch rejection:** 7'h40 (3 cycles), 7'h00 (1 cycle), 7'h79 (3 cycles) → oValid for 0 then 1 only. No oIllegal, no oSeqErr.
- **Skip:** 0, 1, 3, 4, each held 2 cycles → oSeqErr once, coincident with oValid for 3. oErrCount=1. Digit 4 is accepted cleanly.
- **Illegal and blank:**
  - 7'h00 held 2 cycles while LOCKED → oIllegal pulse, oLocked=0, oErrCount+1, oData unchanged.
  - Then 7'h7F held 2 cycles → oBlank=1, no error.
  - Then 7'h12 → oValid, oData=5, oBlank=0, oLocked=1, no oSeqErr.
- **Saturation:** ERR_CNT_W=2, drive 5 sequence errors → oErrCount reads 1, 2, 3, 3, 3.
- **Reset mid-operation:** assert rst for 1 cycle mid-run of digit 6, while LOCKED with oErrCount=2 → all outputs read 0 after that edge, including oLocked. Holding 7'h02 afterwards gives oValid only after 2 further edges.

Source files
------------

// File: rtl/seg7_decode_monitor_if.sv
// Display-bus bundle between the counter/display path (master) and the
// segment decode monitor (slave).
interface seg7_decode_monitor_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic [6:0]           iSeg;
    logic [2:0]           oData;
    logic                 oValid;
    logic                 oIllegal;
    logic                 oBlank;
    logic                 oLocked;
    logic                 oSeqErr;
    logic [ERR_CNT_W-1:0] oErrCount;

    modport master (
        output iSeg,
        input  oData, oValid, oIllegal, oBlank, oLocked, oSeqErr, oErrCount
    );

    modport slave (
        input  iSeg,
        output oData, oValid, oIllegal, oBlank, oLocked, oSeqErr, oErrCount
    );
endinterface

// File: rtl/seg7_decode_monitor.sv
// Decodes the active-low 7-segment display bus back to a 3-bit digit, filters
// glitches, flags illegal patterns and checks that digits step by +1 mod 8.
module seg7_decode_monitor #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    seg7_decode_monitor_if.slave  bus
);
    localparam int unsigned RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0]     RUN_MAX   = RUN_W'(STABLE_CYCLES);
    localparam logic [6:0]           SEG_BLANK = 7'h7F;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t               state, state_next;
    logic [6:0]           s_prev;
    logic [RUN_W-1:0]     run, run_next;
    logic                 changed, accept;
    logic                 is_legal, is_blank;
    logic [2:0]           digit;
    logic [2:0]           expect_q, expect_next;
    logic [2:0]           data_next;
    logic                 valid_next, illegal_next, blank_next, seq_err_next;
    logic [ERR_CNT_W-1:0] err_next;

    // Stability filter: one accept per run that reaches STABLE_CYCLES samples
    always_comb begin
        changed = (bus.iSeg != s_prev);
        if (changed)
            run_next = RUN_W'(1);
        else if (run == RUN_MAX)
            run_next = RUN_MAX;
        else
            run_next = run + RUN_W'(1);
        accept = (run_next == RUN_MAX) && (changed || (run != RUN_MAX));
    end

    // Segment pattern to digit
    always_comb begin
        is_legal = 1'b1;
        digit    = 3'd0;
        case (bus.iSeg)
            7'h40:   digit = 3'd0;
            7'h79:   digit = 3'd1;
            7'h24:   digit = 3'd2;
            7'h30:   digit = 3'd3;
            7'h19:   digit = 3'd4;
            7'h12:   digit = 3'd5;
            7'h02:   digit = 3'd6;
            7'h78:   digit = 3'd7;
            default: is_legal = 1'b0;
        endcase
        is_blank = (bus.iSeg == SEG_BLANK);
    end

    // Sequence checker next-state and output decode
    always_comb begin
        state_next   = state;
        expect_next  = expect_q;
        data_next    = bus.oData;
        blank_next   = bus.oBlank;
        valid_next   = 1'b0;
        illegal_next = 1'b0;
        seq_err_next = 1'b0;
        err_next     = bus.oErrCount;

        if (accept) begin
            if (is_legal) begin
                valid_next   = 1'b1;
                data_next    = digit;
                blank_next   = 1'b0;
                expect_next  = digit + 3'd1;
                seq_err_next = (state == ST_LOCKED) && (digit != expect_q);
                state_next   = ST_LOCKED;
            end else if (is_blank) begin
                blank_next = 1'b1;
                state_next = ST_UNLOCKED;
            end else begin
                illegal_next = 1'b1;
                state_next   = ST_UNLOCKED;
            end
        end

        if ((seq_err_next || illegal_next) && (bus.oErrCount != ERR_MAX))
            err_next = bus.oErrCount + ERR_CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state         <= ST_UNLOCKED;
            s_prev        <= SEG_BLANK;
            run           <= '0;
            expect_q      <= '0;
            bus.oData     <= '0;
            bus.oValid    <= 1'b0;
            bus.oIllegal  <= 1'b0;
            bus.oBlank    <= 1'b0;
            bus.oLocked   <= 1'b0;
            bus.oSeqErr   <= 1'b0;
            bus.oErrCount <= '0;
        end else begin
            state         <= state_next;
            s_prev        <= bus.iSeg;
            run           <= run_next;
            expect_q      <= expect_next;
            bus.oData     <= data_next;
            bus.oValid    <= valid_next;
            bus.oIllegal  <= illegal_next;
            bus.oBlank    <= blank_next;
            bus.oLocked   <= (state_next == ST_LOCKED);
            bus.oSeqErr   <= seq_err_next;
            bus.oErrCount <= err_next;
        end
    end
endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Drives two monitor configurations from one segment bus and compares every
// output, every cycle, against a run-length based reference model.
module tb_seg7_decode_monitor;
    localparam int unsigned S_A = 2;
    localparam int unsigned W_A = 2;
    localparam int unsigned S_B = 1;
    localparam int unsigned W_B = 8;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h7F;

    always #5 CLK = ~CLK;

    seg7_decode_monitor_if #(.ERR_CNT_W(W_A)) bus_a ();
    seg7_decode_monitor_if #(.ERR_CNT_W(W_B)) bus_b ();
    assign bus_a.iSeg = seg;
    assign bus_b.iSeg = seg;

    seg7_decode_monitor #(.STABLE_CYCLES(S_A), .ERR_CNT_W(W_A)) dut_a (
        .CLK(CLK), .rst(rst), .bus(bus_a));
    seg7_decode_monitor #(.STABLE_CYCLES(S_B), .ERR_CNT_W(W_B)) dut_b (
        .CLK(CLK), .rst(rst), .bus(bus_b));

    typedef struct {
        int         s;
        int         cmax;
        logic [6:0] prev;
        int         len;
        int         data;
        int         valid, illegal, blank, locked, seqerr;
        int         errcnt;
        int         expct;
    } mdl_t;

    mdl_t       m [2];
    logic [6:0] codes [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int digit_of(input logic [6:0] x);
        for (int d = 0; d < 8; d++)
            if (codes[d] == x) return d;
        return -1;
    endfunction

    // Reference: an accept happens when the current run length reaches s exactly
    task automatic step_model(input int i);
        int d;
        if (rst) begin
            m[i].prev = 7'h7F; m[i].len = 0; m[i].data = 0;
            m[i].valid = 0; m[i].illegal = 0; m[i].blank = 0;
            m[i].locked = 0; m[i].seqerr = 0; m[i].errcnt = 0; m[i].expct = 0;
            return;
        end
        m[i].valid = 0; m[i].illegal = 0; m[i].seqerr = 0;
        m[i].len  = (seg == m[i].prev) ? m[i].len + 1 : 1;
        m[i].prev = seg;
        if (m[i].len != m[i].s) return;
        d = digit_of(seg);
        if (d >= 0) begin
            m[i].valid = 1;
            m[i].data  = d;
            m[i].blank = 0;
            if (m[i].locked != 0 && d != m[i].expct) begin
                m[i].seqerr = 1;
                if (m[i].errcnt < m[i].cmax) m[i].errcnt++;
            end
            m[i].locked = 1;
            m[i].expct  = (d + 1) % 8;
        end else if (seg == 7'h7F) begin
            m[i].blank  = 1;
            m[i].locked = 0;
        end else begin
            m[i].illegal = 1;
            m[i].locked  = 0;
            if (m[i].errcnt < m[i].cmax) m[i].errcnt++;
        end
    endtask

    task automatic compare_all();
        check_val("a_data",    int'(bus_a.oData),     m[0].data);
        check_val("a_valid",   int'(bus_a.oValid),    m[0].valid);
        check_val("a_illegal", int'(bus_a.oIllegal),  m[0].illegal);
        check_val("a_blank",   int'(bus_a.oBlank),    m[0].blank);
        check_val("a_locked",  int'(bus_a.oLocked),   m[0].locked);
        check_val("a_seqerr",  int'(bus_a.oSeqErr),   m[0].seqerr);
        check_val("a_errcnt",  int'(bus_a.oErrCount), m[0].errcnt);
        check_val("b_data",    int'(bus_b.oData),     m[1].data);
        check_val("b_valid",   int'(bus_b.oValid),    m[1].valid);
        check_val("b_illegal", int'(bus_b.oIllegal),  m[1].illegal);
        check_val("b_blank",   int'(bus_b.oBlank),    m[1].blank);
        check_val("b_locked",  int'(bus_b.oLocked),   m[1].locked);
        check_val("b_seqerr",  int'(bus_b.oSeqErr),   m[1].seqerr);
        check_val("b_errcnt",  int'(bus_b.oErrCount), m[1].errcnt);
    endtask

    task automatic tick();
        @(posedge CLK);
        step_model(0);
        step_model(1);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [6:0] x, input int n);
        seg = x;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int nvalid;
        int cur;
        int r;
        m[0].s = S_A; m[0].cmax = (1 << W_A) - 1;
        m[1].s = S_B; m[1].cmax = (1 << W_B) - 1;

        // Reset state
        seg = 7'h7F;
        do_reset();
        check_val("rst_locked", int'(bus_a.oLocked), 0);
        check_val("rst_errcnt", int'(bus_a.oErrCount), 0);
        hold(7'h7F, 2);
        check_val("rst_blank_accept", int'(bus_a.oBlank), 1);

        // Clean count 0..7,0 held 3 cycles each
        nvalid = 0;
        for (int d = 0; d < 9; d++) begin
            seg = codes[d % 8];
            repeat (3) begin
                tick();
                nvalid += int'(bus_a.oValid);
            end
        end
        check_val("clean_valid_cnt", nvalid, 9);
        check_val("clean_errcnt", int'(bus_a.oErrCount), 0);
        check_val("clean_data", int'(bus_a.oData), 0);

        // Glitch rejection
        hold(7'h40, 3); hold(7'h00, 1); hold(7'h79, 3);
        // Skip: 0,1,3,4
        hold(codes[0], 2); hold(codes[1], 2); hold(codes[3], 2); hold(codes[4], 2);
        // Illegal, blank, then 5
        hold(7'h00, 2); hold(7'h7F, 2); hold(codes[5], 2);
        check_val("after_blank_data", int'(bus_a.oData), 5);

        // Saturation on the 2-bit counter
        do_reset();
        hold(codes[0], 2);
        for (int k = 1; k <= 5; k++) begin
            hold(codes[(2 * k) % 8], 2);
            check_val("sat_errcnt", int'(bus_a.oErrCount), (k < 3) ? k : 3);
        end

        // Reset mid-run of digit 6 while locked with two errors
        do_reset();
        hold(codes[0], 2); hold(codes[2], 2); hold(codes[4], 2);
        seg = codes[6];
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_locked", int'(bus_a.oLocked), 0);
        check_val("midrst_errcnt", int'(bus_a.oErrCount), 0);
        tick();
        check_val("midrst_valid_early", int'(bus_a.oValid), 0);
        tick();
        check_val("midrst_valid", int'(bus_a.oValid), 1);
        check_val("midrst_data", int'(bus_a.oData), 6);

        // Randomized traffic
        cur = 0;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_reset();
            end else if (r <= 12) begin
                cur = (cur + 1) % 8;
                hold(codes[cur], int'($urandom_range(1, 4)));
            end else if (r <= 14) begin
                cur = int'($urandom_range(0, 7));
                hold(codes[cur], int'($urandom_range(1, 4)));
            end else if (r <= 16) begin
                hold(7'h7F, int'($urandom_range(1, 4)));
            end else begin
                hold(7'($urandom), int'($urandom_range(1, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
